// File: rtl/manchester_decoder.sv
// Manchester line decoder: two half-bit samples per bit, LSB-first bytes, per-bit and per-byte violation flags.
// Optional saturating violation counter is built when MANCH_DEC_ERRCNT_EN is defined.
module manchester_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       decode_mode,
  input  logic       line_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       byte_err,
  output logic       code_err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } state_t;

  state_t     state;
  logic       h1;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       err_flag;

  logic       bit_dec;
  logic       viol;
  logic [7:0] shift_next;

  always_comb begin
    bit_dec    = decode_mode ? ~h1 : h1;
    viol       = (line_in == h1);
    shift_next = {bit_dec, shift_reg[7:1]};
  end

  // Output strobe: data_valid is a one-cycle pulse with no back-pressure; data_out
  // and byte_err are valid in that same cycle, and data_out holds until the next pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_WAIT;
      h1         <= 1'b0;
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      err_flag   <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      byte_err   <= 1'b0;
      code_err   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      byte_err   <= 1'b0;
      code_err   <= 1'b0;
      case (state)
        // The encoder's output register still shows its reset value on this edge.
        ST_WAIT: begin
          state <= ST_FIRST;
        end
        ST_FIRST: begin
          h1    <= line_in;
          state <= ST_SECOND;
        end
        ST_SECOND: begin
          shift_reg <= shift_next;
          code_err  <= viol;
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            data_out   <= shift_next;
            data_valid <= 1'b1;
            byte_err   <= err_flag | viol;
            err_flag   <= 1'b0;
          end else begin
            err_flag <= err_flag | viol;
          end
          state <= ST_FIRST;
        end
        default: begin
          state <= ST_WAIT;
        end
      endcase
    end
  end

`ifdef MANCH_DEC_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'h00;
    end else if (code_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_manchester_decoder.sv
// Randomized scoreboard bench for manchester_decoder: a bit-level line model predicts
// every strobed byte, its error flag and strobe edge, plus violation totals.
module tb_manchester_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       decode_mode = 1'b0;
  logic       line_in = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       byte_err;
  logic       code_err;
  logic [7:0] err_count;

  manchester_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .decode_mode (decode_mode),
    .line_in     (line_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .byte_err    (byte_err),
    .code_err    (code_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic       exp_err_q[$];
  int         exp_edge_q[$];

  int         edge_cnt;
  int         code_err_seen = 0;
  int         model_viol = 0;
  int         model_nbits = 0;
  int         model_bytes = 0;
  logic [7:0] model_acc = 8'h00;
  logic       model_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Monitor: samples 1 time unit after each rising edge.
  logic [7:0] mon_d;
  logic       mon_e;
  int         mon_g;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (code_err === 1'b1) code_err_seen++;
      if (data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL strobe: unexpected data_valid with data_out=%02h, expected no strobe", data_out);
        end else begin
          mon_d = exp_q.pop_front();
          mon_e = exp_err_q.pop_front();
          mon_g = exp_edge_q.pop_front();
          check("data_out", 32'(data_out), 32'(mon_d));
          check("byte_err", 32'(byte_err), 32'(mon_e));
          check("strobe_edge", edge_cnt, mon_g);
        end
      end else begin
        check("byte_err_idle", 32'(byte_err), 32'd0);
      end
    end
  end

  // One bit on the line: first half h1, second half h2; the model decides it from the rules.
  task automatic send_raw(input logic h1, input logic h2, input logic dm);
    @(negedge clk);
    line_in     = h1;
    decode_mode = dm;
    @(negedge clk);
    line_in = h2;
    if (h1 == h2) begin
      model_viol++;
      model_err = 1'b1;
    end
    model_acc[model_nbits] = h1 ^ dm;
    model_nbits++;
    if (model_nbits == 8) begin
      exp_q.push_back(model_acc);
      exp_err_q.push_back(model_err);
      exp_edge_q.push_back(17 + 16 * model_bytes);
      model_bytes++;
      model_nbits = 0;
      model_err   = 1'b0;
    end
  endtask

  // Encoder behaviour: IEEE first half = bit, Thomas first half = ~bit; vmask bits repeat the first half.
  task automatic send_byte(input logic [7:0] d, input logic enc_mode, input logic dm,
                           input logic [7:0] vmask);
    logic a;
    for (int i = 0; i < 8; i++) begin
      a = d[i] ^ enc_mode;
      send_raw(a, vmask[i] ? a : ~a, dm);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_byte_err", 32'(byte_err), 32'd0);
    check("rst_code_err", 32'(code_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'h00);
    exp_q.delete();
    exp_err_q.delete();
    exp_edge_q.delete();
    code_err_seen = 0;
    model_viol    = 0;
    model_nbits   = 0;
    model_bytes   = 0;
    model_acc     = 8'h00;
    model_err     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    line_in     = 1'b0;
    decode_mode = 1'b0;
    rst_n       = 1'b1;
  endtask

  task automatic check_phase(input string name);
    int exp_cnt;
    @(posedge clk);
    #3;
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_code_errs"}, code_err_seen, model_viol);
    @(posedge clk);
    #3;
`ifdef MANCH_DEC_ERRCNT_EN
    exp_cnt = (model_viol > 255) ? 255 : model_viol;
`else
    exp_cnt = 0;
`endif
    check({name, "_err_count"}, 32'(err_count), exp_cnt);
  endtask

  logic [7:0] rd;
  logic [7:0] rm;
  logic       re;
  logic       rdm;

  initial begin
    repeat (3) @(posedge clk);

    do_reset();
    repeat (3) send_byte(8'hA5, 1'b0, 1'b0, 8'h00);
    check_phase("ieee_a5");

    do_reset();
    send_byte(8'h3C, 1'b1, 1'b1, 8'h00);
    send_byte(8'h3C, 1'b1, 1'b0, 8'h00);
    check_phase("thomas_3c");

    do_reset();
    send_byte(8'hFF, 1'b0, 1'b0, 8'h04);
    send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0, 8'h00);
    check_phase("viol_bit2");

    do_reset();
    for (int i = 0; i < 300; i++) send_raw(1'b0, 1'b0, 1'b0);
    check_phase("const_zero");

    do_reset();
    for (int i = 0; i < 4; i++) send_raw(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    do_reset();
    send_byte(8'h5A, 1'b0, 1'b0, 8'h00);
    send_byte(8'h96, 1'b1, 1'b1, 8'h00);
    check_phase("mid_reset");

    do_reset();
    for (int n = 0; n < 40; n++) begin
      rd  = 8'($urandom_range(0, 255));
      re  = 1'($urandom_range(0, 1));
      rdm = 1'($urandom_range(0, 1));
      rm  = 8'h00;
      for (int i = 0; i < 8; i++) rm[i] = ($urandom_range(0, 7) == 0);
      send_byte(rd, re, rdm, rm);
    end
    check_phase("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/manchester_decoder.md
# manchester_decoder

Serial Manchester decoder that recovers bytes from the single-wire stream produced by the team's Manchester encoder. It shares the encoder's clock and reset and expects two line half-periods per bit, one clock cycle each, LSB first, eight bits per byte, back to back. Decoded bytes are presented with a one-cycle valid strobe. Violations (no mid-bit transition) are flagged per bit and per byte.

## Interface
- No parameters.
- clk  input  1  system clock, same clock as the encoder; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset; deassert synchronously with the encoder's reset
- decode_mode  input  1  0 = IEEE (first half equals data bit), 1 = Thomas (first half equals inverted data bit)
- line_in  input  1  encoded serial line, one half-bit per clk
- data_out  output  8  last decoded byte, LSB = first received bit
- data_valid  output  1  one-cycle pulse, data_out updated this cycle
- byte_err  output  1  qualifies data_valid: at least one violation in this byte
- code_err  output  1  one-cycle pulse per violating bit
- err_count  output  8  saturating violation counter (see Configuration)

## Operation
- Edge numbering: edge 1 is the first rising clk edge after rst_n deasserts.
- State machine:
  - WAIT: edge 1 discards line_in, because the encoder's output register still holds its reset value. → FIRST.
  - FIRST: capture line_in into h1. → SECOND.
  - SECOND: compare line_in (h2) with h1. Shift the decoded bit in, advance bit_cnt. → FIRST.
- Bit 0 occupies edges 2/3, bit n edges 2+2n / 3+2n, and byte k bit 0 lands at edge 2+16k.
- Bit decision on the SECOND edge: bit = h1 when decode_mode=0, bit = ~h1 when decode_mode=1. decode_mode is sampled on that edge only.
- Violation when h1 == h2:
  - Bit is still decided by the rule above.
  - code_err pulses.
  - The per-byte error flag is set.
  - Framing is never slipped; alignment comes only from the common reset.
- Shift register shifts right and inserts the new bit at bit 7.
- bit_cnt is 3 bits and wraps 7→0.
- On the SECOND edge with bit_cnt=7:
  - data_out ← complete byte including the current bit.
  - data_valid ← 1.
  - byte_err ← error flag OR current violation.
  - Error flag clears for the next byte.
- data_out holds its value between strobes.
- byte_err is meaningful only while data_valid=1 and is 0 otherwise.

## Timing
- Reset values:
  - Outputs: data_out=0x00, data_valid=0, byte_err=0, code_err=0, err_count=0.
  - Internal: state=WAIT, bit_cnt=0, shift register=0, h1=0, error flag=0.
- Reset asserted mid-byte: immediate return to the reset values; the partial byte is discarded and never strobed.
- First data_valid is high in the cycle after edge 17, then every 16 cycles (edges 33, 49, …).
- code_err is high in the cycle after the offending SECOND edge.
- data_valid and code_err may be high in the same cycle (violation on bit 7).
- Continuous streaming: no idle cycles between bytes; FIRST of the next byte follows the SECOND of bit 7 directly.

## Configuration
- MANCH_DEC_ERRCNT_EN defined:
  - err_count increments by 1 in the cycle after each code_err.
  - It saturates at 0xFF and clears only on reset.
- MANCH_DEC_ERRCNT_EN undefined:
  - The counter logic is not built and err_count is tied to 0x00.
  - code_err and byte_err are unaffected.

## Test plan
- Encoder mode 0, data_in=0xA5, line 10 01 10 01 01 10 01 10 from edge 2 → data_valid after edges 17, 33, 49 with data_out=0xA5, byte_err=0, code_err never high.
- Encoder mode 1, data_in=0x3C, decoder decode_mode=1 → data_out=0x3C. Same stream with decode_mode=0 → data_out=0xC3, no violations.
- Bench drives line_in=1 on both halves of bit 2 of byte 0 (edges 6/7), data 0xFF mode 0 → code_err pulse after edge 7, data_valid after edge 17 with data_out=0xFF and byte_err=1. Next byte has byte_err=0. err_count=1 with macro, 0 without.
- Constant line_in=0 for 300 bits, macro defined → code_err every second cycle, err_count saturates at 0xFF, every byte strobed with byte_err=1 and data_out=0x00 (mode 0).
- rst_n pulled low asynchronously mid-cycle at edge 10, released for edge 20 alongside encoder reset → outputs go to reset values immediately, no strobe for the partial byte, next data_valid after edge 36 relative to the original count (edge 17 of the new numbering) with the correct byte.
